// File: rtl/rgb_pwm_led_array.sv
`default_nettype none
// ============================================================================
// rgb_pwm_led_array : N_LED RGB LEDs with per-LED colour/PWM duty, blink mode
//                     and on-chip synchronised, debounced button control.
// Revision 1.0
// ============================================================================
module rgb_pwm_led_array #(
  parameter int N_LED           = 2,
  parameter int PWM_BITS        = 8,
  parameter int BRIGHT_STEP     = 32,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BLINK_DIV       = 2**24,
  localparam int SEL_W          = (N_LED > 1) ? $clog2(N_LED) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               switch0,
  input  logic               switch1,
  input  logic [3:0]         button,
  output logic [3*N_LED-1:0] RGB_LED,
  output logic [SEL_W-1:0]   sel_led
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [PWM_BITS-1:0] DMAX   = '1;
  localparam logic [PWM_BITS-1:0] STEP   = PWM_BITS'(BRIGHT_STEP);
  localparam logic [PWM_BITS:0]   STEP_X = (PWM_BITS + 1)'(BRIGHT_STEP);

  logic [3:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]          deb_q, deb_d, arm_q, arm_d, press_q, press_d;
  logic [DW-1:0]       dcnt_q [4];
  logic [DW-1:0]       dcnt_d [4];
  logic [1:0]          vld_q, vld_d;
  logic [2:0]          colour_q [N_LED];
  logic [2:0]          colour_d [N_LED];
  logic [PWM_BITS-1:0] duty_q [N_LED];
  logic [PWM_BITS-1:0] duty_d [N_LED];
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [BW-1:0]       blink_q, blink_d;
  logic                phase_q, phase_d;
  logic [3*N_LED-1:0]  rgb_q, rgb_d;

  function automatic logic [PWM_BITS-1:0] sat_add(input logic [PWM_BITS-1:0] d);
    logic [PWM_BITS:0] s;
    s = {1'b0, d} + STEP_X;
    return (s > {1'b0, DMAX}) ? DMAX : s[PWM_BITS-1:0];
  endfunction

  function automatic logic [PWM_BITS-1:0] sat_sub(input logic [PWM_BITS-1:0] d);
    return (d < STEP) ? '0 : d - STEP;
  endfunction

  always_comb begin
    sync1_d = button;
    sync2_d = sync1_q;
    vld_d   = {vld_q[0], 1'b1};
    for (int i = 0; i < 4; i++) begin
      deb_d[i]  = deb_q[i];
      dcnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) deb_d[i] = sync2_q[i];
        else dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
    end
    // A button only arms once a genuine released sample has passed the
    // synchroniser, so a button held through reset never yields a press.
    arm_d   = arm_q | ({4{vld_q[1]}} & ~sync2_q);
    press_d = deb_d & ~deb_q & arm_q;
  end

  always_comb begin
    sel_d = sel_q;
    if (press_q[3]) sel_d = (sel_q == SEL_W'(N_LED - 1)) ? '0 : sel_q + 1'b1;
    for (int k = 0; k < N_LED; k++) begin
      colour_d[k] = colour_q[k];
      duty_d[k]   = duty_q[k];
      if (sel_q == SEL_W'(k)) begin
        if (press_q[0]) colour_d[k] = colour_q[k] + 3'd1;
        if (press_q[1] && !press_q[2]) duty_d[k] = sat_add(duty_q[k]);
        if (press_q[2] && !press_q[1]) duty_d[k] = sat_sub(duty_q[k]);
      end
    end
  end

  always_comb begin
    pwm_d   = pwm_q + 1'b1;
    blink_d = blink_q + 1'b1;
    phase_d = phase_q;
    if (blink_q == BW'(BLINK_DIV - 1)) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end
    for (int k = 0; k < N_LED; k++) begin
      for (int c = 0; c < 3; c++) begin
        rgb_d[3*k+c] = switch0 & (pwm_q < duty_q[k]) & colour_q[k][c] & (~switch1 | phase_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      arm_q   <= '0;
      press_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < 4; i++) dcnt_q[i] <= '0;
      for (int k = 0; k < N_LED; k++) begin
        colour_q[k] <= '0;
        duty_q[k]   <= DMAX;
      end
      sel_q   <= '0;
      pwm_q   <= '0;
      blink_q <= '0;
      phase_q <= 1'b1;
      rgb_q   <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb_q    <= deb_d;
      arm_q    <= arm_d;
      press_q  <= press_d;
      vld_q    <= vld_d;
      dcnt_q   <= dcnt_d;
      colour_q <= colour_d;
      duty_q   <= duty_d;
      sel_q    <= sel_d;
      pwm_q    <= pwm_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
      rgb_q    <= rgb_d;
    end
  end

  assign RGB_LED = rgb_q;
  assign sel_led = sel_q;

endmodule
`default_nettype wire
